// File: rtl/uart_rx_framed_if.sv
// Control and status bundle for uart_rx_framed: serial line, frame request/abort,
// received data and sticky result flags.
interface uart_rx_framed_if #(
    parameter int DATA_BITS = 8
);
    logic                 din;
    logic                 start_rx;
    logic                 abort;
    logic                 busy;
    logic [DATA_BITS-1:0] dout;
    logic                 is_byte_valid;
    logic                 is_byte_corrupt;
    logic                 frame_error;
    logic                 byte_timed_out;

    modport master (
        output din, start_rx, abort,
        input  busy, dout, is_byte_valid, is_byte_corrupt, frame_error, byte_timed_out
    );

    modport slave (
        input  din, start_rx, abort,
        output busy, dout, is_byte_valid, is_byte_corrupt, frame_error, byte_timed_out
    );
endinterface

// File: rtl/uart_rx_framed.sv
// Single-shot UART receiver: armed by start_rx, receives one frame with optional
// parity and 1-2 stop bits, and reports a sticky result or a start-bit timeout.
module uart_rx_framed #(
    parameter int DATA_BITS      = 8,
    parameter int CLKS_PER_BIT   = 8,
    parameter int PARITY_MODE    = 1,
    parameter int STOP_BITS      = 2,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int ALIGN_STAGES   = 3
) (
    input logic          clk,
    input logic          rst_n,
    uart_rx_framed_if.slave bus
);

    localparam int SYNC_LEN = 2 + ALIGN_STAGES;
    localparam int TW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW       = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] BIT_HALF  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE, WAIT_START, VERIFY_START, DATA, PARITY, STOP, DONE
    } state_t;

    state_t               state;
    logic [SYNC_LEN-1:0]  sync_q;
    logic                 sd_d1;
    logic                 sd_d2;
    logic [TW-1:0]        bit_tmr;
    logic [CW-1:0]        to_cnt;
    logic [3:0]           bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 par_acc;
    logic                 par_err;
    logic                 stop_err;

    logic sd;
    logic fall;
    logic sample;
    logic at_sample;

    assign sd        = sync_q[SYNC_LEN-1];
    assign fall      = ~sd & sd_d1;
    // Majority vote over the current and two previous line samples.
    assign sample    = (sd & sd_d1) | (sd & sd_d2) | (sd_d1 & sd_d2);
    assign at_sample = (bit_tmr == BIT_LAST);

    // NOTE: the line pipeline resets high so an idle line is never mistaken for a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            sd_d1  <= 1'b1;
            sd_d2  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            sync_q <= {sync_q[SYNC_LEN-2:0], bus.din};
            sd_d1  <= sd;
            sd_d2  <= sd_d1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= IDLE;
            bit_tmr             <= '0;
            to_cnt              <= '0;
            bit_cnt             <= '0;
            shift_q             <= '0;
            par_acc             <= 1'b0;
            par_err             <= 1'b0;
            stop_err            <= 1'b0;
            bus.busy            <= 1'b0;
            bus.dout            <= '0;
            bus.is_byte_valid   <= 1'b0;
            bus.is_byte_corrupt <= 1'b0;
            bus.frame_error     <= 1'b0;
            bus.byte_timed_out  <= 1'b0;
        end else if (state != IDLE && bus.abort) begin
            state    <= IDLE;
            bus.busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_rx) begin
                        bus.dout            <= '0;
                        bus.is_byte_valid   <= 1'b0;
                        bus.is_byte_corrupt <= 1'b0;
                        bus.frame_error     <= 1'b0;
                        bus.byte_timed_out  <= 1'b0;
                        to_cnt              <= '0;
                        bus.busy            <= 1'b1;
                        state               <= WAIT_START;
                    end
                end

                WAIT_START: begin
                    if (fall) begin
                        bit_tmr <= '0;
                        state   <= VERIFY_START;
                    end else if (to_cnt == TO_LAST) begin
                        bus.byte_timed_out <= 1'b1;
                        bus.busy           <= 1'b0;
                        state              <= IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end

                VERIFY_START: begin
                    if (bit_tmr == BIT_HALF) begin
                        if (sample) begin
                            // Glitch: re-arm but keep the timeout budget already spent.
                            state <= WAIT_START;
                        end else begin
                            bit_tmr  <= '0;
                            bit_cnt  <= '0;
                            par_acc  <= 1'b0;
                            par_err  <= 1'b0;
                            stop_err <= 1'b0;
                            state    <= DATA;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                DATA: begin
                    if (at_sample) begin
                        bit_tmr <= '0;
                        shift_q <= {sample, shift_q[DATA_BITS-1:1]};
                        par_acc <= par_acc ^ sample;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PARITY_MODE != 0) ? PARITY : STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                PARITY: begin
                    if (at_sample) begin
                        bit_tmr <= '0;
                        par_err <= (PARITY_MODE == 1) ? ~(par_acc ^ sample) : (par_acc ^ sample);
                        state   <= STOP;
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                STOP: begin
                    if (at_sample) begin
                        bit_tmr <= '0;
                        if (!sample) stop_err <= 1'b1;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            state   <= DONE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        bit_tmr <= bit_tmr + 1'b1;
                    end
                end

                DONE: begin
                    bus.dout            <= shift_q;
                    bus.frame_error     <= stop_err;
                    bus.is_byte_corrupt <= par_err;
                    bus.is_byte_valid   <= ~stop_err & ~par_err;
                    bus.busy            <= 1'b0;
                    state               <= IDLE;
                end

                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/uart_rx_framed.md
UART_RX_FRAMED -- requirements
Module: uart_rx_framed

Interface
REQ-001 SHALL have parameter DATA_BITS, 8, data bits per frame, legal 5..9, LSB first.
REQ-002 SHALL have parameter CLKS_PER_BIT, 8, clk cycles per bit, legal 4..255.
REQ-003 SHALL have parameter PARITY_MODE, 1, 0 none / 1 odd / 2 even.
REQ-004 SHALL have parameter STOP_BITS, 2, legal 1 or 2.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 500, max wait for start bit after start_rx.
REQ-006 SHALL have parameter ALIGN_STAGES, 3, extra din delay flops after the 2-flop synchronizer.
REQ-007 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have port din  in  1  asynchronous serial line, idle high.
REQ-010 SHALL have port start_rx  in  1  request to arm receiver for one frame.
REQ-011 SHALL have port abort  in  1  cancel an armed or in-progress frame.
REQ-012 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-013 SHALL have port dout  out  DATA_BITS  received data.
REQ-014 SHALL have port is_byte_valid  out  1  frame received, parity and stop bits good.
REQ-015 SHALL have port is_byte_corrupt  out  1  parity check failed.
REQ-016 SHALL have port frame_error  out  1  any stop bit sampled low.
REQ-017 SHALL have port byte_timed_out  out  1  no start bit within TIMEOUT_CYCLES.

Function
REQ-018 SHALL pass din through 2 synchronizer flops then ALIGN_STAGES flops; "sd" = last stage output; falling edge = sd low while previous sd high.
REQ-019 SHALL implement states IDLE, WAIT_START, VERIFY_START, DATA, PARITY, STOP, DONE.
REQ-020 IDLE: start_rx high -> clear dout to 0, clear all four status flags, zero timeout counter, go WAIT_START; start_rx outside IDLE ignored.
REQ-021 WAIT_START: falling edge -> zero bit timer, go VERIFY_START; else timeout counter reaching TIMEOUT_CYCLES-1 -> set byte_timed_out, go IDLE (flag visible TIMEOUT_CYCLES cycles after start_rx cycle); edge and timeout same cycle -> edge wins.
REQ-022 Sample value at each sample point SHALL be majority of sd over that cycle and the two preceding cycles.
REQ-023 VERIFY_START: sample point at bit timer = CLKS_PER_BIT/2 - 1 (integer division); sample 1 -> glitch, back to WAIT_START without zeroing timeout counter; sample 0 -> zero bit timer, go DATA.
REQ-024 Each later sample point SHALL occur when bit timer = CLKS_PER_BIT-1, then bit timer zeroes.
REQ-025 DATA: shift DATA_BITS samples LSB first; after last -> PARITY if PARITY_MODE != 0 else STOP.
REQ-026 PARITY: one sample; odd mode error when XOR(data, parity) = 0, even mode error when = 1; go STOP.
REQ-027 STOP: STOP_BITS samples; any 0 records frame error; after last -> DONE.
REQ-028 DONE (one cycle): load dout; set frame_error and/or is_byte_corrupt per recorded errors; set is_byte_valid only if neither; go IDLE.
REQ-029 Status flags SHALL be sticky until next accepted start_rx or reset; is_byte_valid exclusive with the other three.
REQ-030 abort high in any non-IDLE state -> IDLE next cycle, no flag set, dout unchanged; abort in IDLE no effect; abort beats all other transitions.
REQ-031 Timeout counter SHALL saturate, not wrap; bit timer width = ceil(log2(CLKS_PER_BIT)) bits.
REQ-032 Status flags SHALL assert CLKS_PER_BIT*(DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) + CLKS_PER_BIT/2 + 1 cycles after falling-edge detection.

Reset
REQ-033 rst_n low SHALL asynchronously force state IDLE, all synchronizer/delay flops high (idle line), counters 0, dout 0, busy 0, all status flags 0.
REQ-034 Reset mid-frame SHALL discard the frame; first start_rx after rst_n rises SHALL behave as from power-up.

Verification (defaults unless stated)
REQ-035 start_rx, frame 0xA5, parity 1, two stop 1s -> is_byte_valid=1, dout=0xA5, others 0, at REQ-032 latency (93 cycles).
REQ-036 Same frame, parity 0 -> is_byte_corrupt=1, is_byte_valid=0, dout=0xA5.
REQ-037 start_rx, din held high -> byte_timed_out=1 exactly 500 cycles after start_rx, busy=0.
REQ-038 2-cycle low glitch then frame 0x3C parity 1 -> glitch rejected, is_byte_valid=1, dout=0x3C; second stop bit low -> frame_error=1 only.
REQ-039 abort during bit 3, and separately rst_n low during bit 5 -> IDLE, no flags; reset case dout=0.
REQ-040 DATA_BITS=7, PARITY_MODE=2, STOP_BITS=1, CLKS_PER_BIT=16, frame 0x55 parity 0 -> is_byte_valid=1, dout=0x55.
